// File: rtl/hier_child_sequencer.sv
// Start/wait controller for one hierarchy node: issues start pulses to enabled children
// sequentially (index order) or all at once, with per-child or per-run timeout reporting.
module hier_child_sequencer #(
    parameter int  NUM_CHILD = 5,
    parameter int  TIMEOUT_W = 8,
    localparam int IDX_W     = (NUM_CHILD > 1) ? $clog2(NUM_CHILD) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start_i,
    input  logic                 mode_i,
    input  logic [NUM_CHILD-1:0] enable_mask_i,
    input  logic [TIMEOUT_W-1:0] timeout_cfg_i,
    output logic [NUM_CHILD-1:0] child_start_o,
    input  logic [NUM_CHILD-1:0] child_done_i,
    output logic                 busy_o,
    output logic                 done_o,
    output logic [NUM_CHILD-1:0] status_o,
    output logic [IDX_W-1:0]     cur_idx_o
);

    localparam int PTR_W = IDX_W + 1;

    typedef enum logic [2:0] {
        IDLE,
        SCAN,
        ISSUE,
        WAIT,
        FINISH
    } state_t;

    state_t               state, state_n;
    logic                 mode, mode_n;
    logic [NUM_CHILD-1:0] mask, mask_n;
    logic [TIMEOUT_W-1:0] limit, limit_n;
    logic [TIMEOUT_W-1:0] cnt, cnt_n;
    logic [PTR_W-1:0]     ptr, ptr_n;
    logic [IDX_W-1:0]     cur, cur_n;
    logic [NUM_CHILD-1:0] sticky, sticky_n;
    logic [NUM_CHILD-1:0] status, status_n;

    logic                 found;
    logic [IDX_W-1:0]     found_idx;
    logic [NUM_CHILD-1:0] cur_onehot;
    logic [TIMEOUT_W-1:0] cnt_inc;
    logic                 timeout_hit;
    logic                 seq_done;
    logic [NUM_CHILD-1:0] par_sticky;
    logic                 par_all_done;
    logic [PTR_W-1:0]     ptr_adv;

    // Pointer is one bit wider than the index so that "past the last child" is representable
    // and terminates the run instead of wrapping back to child 0.
    always_comb begin
        found     = 1'b0;
        found_idx = '0;
        for (int i = 0; i < NUM_CHILD; i++) begin
            if (!found && mask[i] && (PTR_W'(i) >= ptr)) begin
                found     = 1'b1;
                found_idx = IDX_W'(i);
            end
        end
    end

    always_comb begin
        cur_onehot = '0;
        for (int i = 0; i < NUM_CHILD; i++) begin
            cur_onehot[i] = (cur == IDX_W'(i));
        end
    end

    assign cnt_inc      = cnt + TIMEOUT_W'(1);
    assign timeout_hit  = (limit != '0) && (cnt_inc == limit);
    assign seq_done     = |(child_done_i & cur_onehot);
    assign par_sticky   = sticky | (child_done_i & mask);
    assign par_all_done = ((par_sticky & mask) == mask);
    assign ptr_adv      = {1'b0, cur} + PTR_W'(1);

    always_comb begin
        state_n       = state;
        mode_n        = mode;
        mask_n        = mask;
        limit_n       = limit;
        cnt_n         = cnt;
        ptr_n         = ptr;
        cur_n         = cur;
        sticky_n      = sticky;
        status_n      = status;
        child_start_o = '0;

        case (state)
            IDLE: begin
                cur_n = '0;
                if (start_i) begin
                    mode_n   = mode_i;
                    mask_n   = enable_mask_i;
                    limit_n  = timeout_cfg_i;
                    status_n = '0;
                    ptr_n    = '0;
                    state_n  = SCAN;
                end
            end

            SCAN: begin
                if (mode) begin
                    state_n = (|mask) ? ISSUE : FINISH;
                end else if (found) begin
                    cur_n   = found_idx;
                    state_n = ISSUE;
                end else begin
                    state_n = FINISH;
                end
            end

            ISSUE: begin
                child_start_o = mode ? mask : cur_onehot;
                cnt_n         = '0;
                sticky_n      = '0;
                state_n       = WAIT;
            end

            WAIT: begin
                cnt_n = cnt_inc;
                if (!mode) begin
                    // A done arriving in the limit cycle takes precedence over the timeout.
                    if (seq_done) begin
                        ptr_n   = ptr_adv;
                        state_n = SCAN;
                    end else if (timeout_hit) begin
                        status_n = status | cur_onehot;
                        ptr_n    = ptr_adv;
                        state_n  = SCAN;
                    end
                end else begin
                    sticky_n = par_sticky;
                    if (par_all_done) begin
                        state_n = FINISH;
                    end else if (timeout_hit) begin
                        status_n = mask & ~par_sticky;
                        state_n  = FINISH;
                    end
                end
            end

            FINISH: begin
                cur_n   = '0;
                state_n = IDLE;
            end

            default: begin
                state_n = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            mode   <= 1'b0;
            mask   <= '0;
            limit  <= '0;
            cnt    <= '0;
            ptr    <= '0;
            cur    <= '0;
            sticky <= '0;
            status <= '0;
        end else begin
            state  <= state_n;
            mode   <= mode_n;
            mask   <= mask_n;
            limit  <= limit_n;
            cnt    <= cnt_n;
            ptr    <= ptr_n;
            cur    <= cur_n;
            sticky <= sticky_n;
            status <= status_n;
        end
    end

    assign busy_o    = (state != IDLE);
    assign done_o    = (state == FINISH);
    assign status_o  = status;
    assign cur_idx_o = cur;

endmodule

// File: tb/tb_hier_child_sequencer.sv
// Scoreboard bench: a timeline model predicts start pulses, done cycle and status per run;
// a monitor compares DUT outputs against the queued predictions.
module tb_hier_child_sequencer;

    localparam int N  = 5;
    localparam int TW = 8;
    localparam int IW = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic          start_i;
    logic          mode_i;
    logic [N-1:0]  enable_mask_i;
    logic [TW-1:0] timeout_cfg_i;
    logic [N-1:0]  child_start_o;
    logic [N-1:0]  child_done_i;
    logic          busy_o;
    logic          done_o;
    logic [N-1:0]  status_o;
    logic [IW-1:0] cur_idx_o;

    hier_child_sequencer #(.NUM_CHILD(N), .TIMEOUT_W(TW)) dut (
        .clk          (clk),
        .rst          (rst),
        .start_i      (start_i),
        .mode_i       (mode_i),
        .enable_mask_i(enable_mask_i),
        .timeout_cfg_i(timeout_cfg_i),
        .child_start_o(child_start_o),
        .child_done_i (child_done_i),
        .busy_o       (busy_o),
        .done_o       (done_o),
        .status_o     (status_o),
        .cur_idx_o    (cur_idx_o)
    );

    typedef struct {
        int           cyc;
        logic [N-1:0] vec;
        int           idx;
    } start_ev_t;

    typedef struct {
        int           cyc;
        logic [N-1:0] st;
    } done_ev_t;

    int           cyc = 0;
    int           checks = 0;
    int           fails = 0;
    int           dly[N];
    int           due[N];
    bit           mon_en = 1'b0;
    int           busy_lo = -1;
    int           busy_hi = -2;
    logic [N-1:0] exp_status = '0;
    start_ev_t    start_q[$];
    done_ev_t     done_q[$];

    // Cycle c is the interval that begins at the posedge where cyc becomes c.
    initial begin
        forever begin
            #5 clk = 1'b1;
            cyc = cyc + 1;
            #5 clk = 1'b0;
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Timeline model: ISSUE at T, child done pulse at T+d, timeout decision at T+tmo.
    task automatic model(input bit md, input logic [N-1:0] mk, input int tmo, input int acc);
        int        t, tt, ptr, d, idx, mx, end_off, fin, f;
        bit        found;
        logic [N-1:0] st;
        start_ev_t se;
        done_ev_t  de;
        st = '0;
        t  = acc + 1;
        if (!md) begin
            ptr = 0;
            while (1) begin
                found = 1'b0;
                idx   = 0;
                for (int i = ptr; i < N; i++) begin
                    if (!found && mk[i]) begin
                        found = 1'b1;
                        idx   = i;
                    end
                end
                if (!found) break;
                tt       = t + 1;
                se.cyc   = tt;
                se.vec   = '0;
                se.vec[idx] = 1'b1;
                se.idx   = idx;
                start_q.push_back(se);
                d = dly[idx];
                if (d != 0 && (tmo == 0 || d <= tmo)) begin
                    t = tt + d + 1;
                end else begin
                    st[idx] = 1'b1;
                    t = tt + tmo + 1;
                end
                ptr = idx + 1;
            end
            fin = t + 1;
        end else if (mk == '0) begin
            fin = acc + 2;
        end else begin
            tt     = acc + 2;
            se.cyc = tt;
            se.vec = mk;
            se.idx = 0;
            start_q.push_back(se);
            mx = 0;
            for (int i = 0; i < N; i++) begin
                if (mk[i]) begin
                    f = (dly[i] == 0) ? 1000000 : dly[i];
                    if (f > mx) mx = f;
                end
            end
            if (tmo != 0 && mx > tmo) begin
                end_off = tmo;
                for (int i = 0; i < N; i++)
                    if (mk[i] && (dly[i] == 0 || dly[i] > tmo)) st[i] = 1'b1;
            end else begin
                end_off = mx;
            end
            fin = tt + end_off + 1;
        end
        de.cyc = fin;
        de.st  = st;
        done_q.push_back(de);
        busy_lo    = acc + 1;
        busy_hi    = fin;
        exp_status = st;
    endtask

    // Child responders: a one-cycle done pulse dly[i] cycles after the start pulse; 0 = silent.
    initial begin
        for (int i = 0; i < N; i++) due[i] = -1;
        child_done_i = '0;
        forever begin
            @(negedge clk);
            for (int i = 0; i < N; i++)
                if (child_start_o[i] && dly[i] != 0) due[i] = cyc + dly[i];
            @(posedge clk);
            #1;
            for (int i = 0; i < N; i++) child_done_i[i] = (due[i] == cyc);
        end
    end

    initial begin
        start_ev_t se;
        done_ev_t  de;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                chk("busy", busy_o, (cyc >= busy_lo && cyc <= busy_hi));
                if (child_start_o !== '0) begin
                    if (start_q.size() == 0) begin
                        chk("unexpected_start", child_start_o, 0);
                    end else begin
                        se = start_q.pop_front();
                        chk("start_cycle", cyc, se.cyc);
                        chk("start_vec", child_start_o, se.vec);
                        chk("cur_idx", cur_idx_o, se.idx);
                    end
                end else if (start_q.size() != 0 && cyc > start_q[0].cyc) begin
                    se = start_q.pop_front();
                    chk("start_missing", cyc, se.cyc);
                end
                if (done_o) begin
                    if (done_q.size() == 0) begin
                        chk("unexpected_done", done_o, 0);
                    end else begin
                        de = done_q.pop_front();
                        chk("done_cycle", cyc, de.cyc);
                        chk("status", status_o, de.st);
                    end
                end else if (done_q.size() != 0 && cyc > done_q[0].cyc) begin
                    de = done_q.pop_front();
                    chk("done_missing", cyc, de.cyc);
                end
            end
        end
    end

    task automatic run(input bit md, input logic [N-1:0] mk, input int tmo, input int extra);
        int acc, w, k;
        @(posedge clk);
        #1;
        acc = cyc;
        model(md, mk, tmo, acc);
        start_i       = 1'b1;
        mode_i        = md;
        enable_mask_i = mk;
        timeout_cfg_i = TW'(tmo);
        @(posedge clk);
        #1;
        start_i       = 1'b0;
        mode_i        = 1'($urandom);
        enable_mask_i = N'($urandom);
        timeout_cfg_i = TW'($urandom);
        k = 0;
        while (k < extra && cyc <= busy_hi) begin
            start_i = 1'b1;
            @(posedge clk);
            #1;
            k++;
        end
        start_i = 1'b0;
        w = 0;
        while ((done_q.size() != 0 || cyc <= busy_hi) && w < 3000) begin
            @(posedge clk);
            w++;
        end
        chk("run_complete", (w < 3000), 1);
        @(negedge clk);
        chk("status_hold", status_o, exp_status);
        repeat (15) @(posedge clk);
    endtask

    initial begin
        int           w;
        logic [N-1:0] seen;
        bit           md;
        logic [N-1:0] mk;
        int           tmo;

        rst           = 1'b1;
        start_i       = 1'b0;
        mode_i        = 1'b0;
        enable_mask_i = '0;
        timeout_cfg_i = '0;
        for (int i = 0; i < N; i++) dly[i] = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_child_start", child_start_o, 0);
        chk("rst_busy", busy_o, 0);
        chk("rst_done", done_o, 0);
        chk("rst_status", status_o, 0);
        chk("rst_cur_idx", cur_idx_o, 0);
        @(posedge clk);
        #1;
        rst    = 1'b0;
        mon_en = 1'b1;

        // Sequential, all children, no timeout, done 3 cycles after start: pulses 5 apart.
        dly = '{3, 3, 3, 3, 3};
        run(1'b0, 5'b11111, 0, 3);

        // Sequential sparse mask, child 2 silent with timeout 4.
        dly = '{2, 0, 0, 0, 2};
        run(1'b0, 5'b10101, 4, 0);

        // Parallel, child 3 silent, run timeout 10.
        dly = '{2, 5, 7, 0, 0};
        run(1'b1, 5'b01111, 10, 2);

        // Sequential, child 0 done lands on the limit cycle.
        dly = '{3, 1, 0, 0, 0};
        run(1'b0, 5'b00011, 3, 0);

        // Empty mask with start re-pulsed while busy.
        run(1'b0, 5'b00000, 0, 2);
        run(1'b1, 5'b00000, 5, 2);

        // Reset during WAIT of child 2.
        mon_en = 1'b0;
        dly = '{2, 0, 0, 2, 2};
        @(posedge clk);
        #1;
        start_i       = 1'b1;
        mode_i        = 1'b0;
        enable_mask_i = 5'b11111;
        timeout_cfg_i = TW'(3);
        @(posedge clk);
        #1;
        start_i = 1'b0;
        w = 0;
        @(negedge clk);
        while (child_start_o[2] !== 1'b1 && w < 200) begin
            @(negedge clk);
            w++;
        end
        chk("reach_child2", (w < 200), 1);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("status_pre_reset", status_o, 5'b00010);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_child_start", child_start_o, 0);
        chk("post_rst_busy", busy_o, 0);
        chk("post_rst_done", done_o, 0);
        chk("post_rst_status", status_o, 0);
        chk("post_rst_cur_idx", cur_idx_o, 0);
        seen = '0;
        repeat (10) begin
            @(negedge clk);
            seen = seen | child_start_o | {{(N-1){1'b0}}, busy_o};
        end
        chk("post_rst_quiet", seen, 0);
        start_q.delete();
        done_q.delete();
        busy_lo = -1;
        busy_hi = -2;
        for (int i = 0; i < N; i++) due[i] = -1;
        mon_en = 1'b1;
        dly = '{3, 3, 3, 3, 3};
        run(1'b0, 5'b11111, 0, 0);

        // Randomised runs.
        for (int r = 0; r < 30; r++) begin
            md  = 1'($urandom_range(0, 1));
            mk  = N'($urandom_range(0, 31));
            tmo = $urandom_range(0, 8);
            for (int i = 0; i < N; i++) begin
                dly[i] = $urandom_range(0, 10);
                if (tmo == 0 && dly[i] == 0) dly[i] = $urandom_range(1, 10);
            end
            run(md, mk, tmo, $urandom_range(0, 3));
        end

        chk("start_q_drained", start_q.size(), 0);
        chk("done_q_drained", done_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/hier_child_sequencer.md
Name: hier_child_sequencer

Overview:
Parametrised controller for a hierarchy level of NUM_CHILD sub-instances, replacing fixed hand-instantiated child lists. On a start request it issues start pulses to the enabled children, either one at a time in index order or all at once. It waits for each child's done with a programmable timeout and reports per-child timeout status. It sits at each hierarchy node between the parent's control and its generated children.

Parameters:
NUM_CHILD, 5, number of child channels (1..64)
TIMEOUT_W, 8, width of timeout counter and timeout_cfg_i
IDX_W, $clog2(NUM_CHILD) min 1, width of cur_idx_o (derived, not overridden)

Ports:
clk  in  1  single clock, rising edge
rst  in  1  synchronous, active-high reset
start_i  in  1  request a run; sampled only in IDLE
mode_i  in  1  0 = sequential, 1 = parallel; sampled with start_i
enable_mask_i  in  NUM_CHILD  children taking part in the run; sampled with start_i
timeout_cfg_i  in  TIMEOUT_W  WAIT-cycle limit per child (sequential) or per run (parallel); 0 = no timeout; sampled with start_i
child_start_o  out  NUM_CHILD  one-cycle start pulse per child
child_done_i  in  NUM_CHILD  child completion, level or pulse
busy_o  out  1  high from the cycle after start is accepted until done_o inclusive
done_o  out  1  one-cycle run-complete pulse
status_o  out  NUM_CHILD  bit i = 1 if child i timed out; held until next accepted start
cur_idx_o  out  IDX_W  child being serviced (sequential); 0 in parallel or idle

Behaviour:
- Reset: state IDLE; child_start_o, busy_o, done_o, status_o, cur_idx_o, counters all 0; latched configuration cleared. Reset mid-run aborts at once and drives no further start pulses.
- States: IDLE, SCAN, ISSUE, WAIT, FINISH.
- IDLE: if start_i, latch mode, mask and timeout; clear status_o; go to SCAN. start_i in any other state is ignored, with no queueing.
- SCAN (sequential): find the lowest enabled index at or above the pointer (pointer is 0 at run start). If found, set cur_idx_o and go to ISSUE. Otherwise go to FINISH. Costs one cycle per visit, not per skipped child.
- SCAN (parallel): if mask is nonzero go to ISSUE, else go to FINISH.
- ISSUE: pulse child_start_o for cur_idx_o (sequential) or for all masked bits (parallel) for exactly one cycle. Clear the timeout counter and the sticky done vector. Go to WAIT.
- child_done_i is ignored during ISSUE and sampled only in WAIT.
- WAIT (sequential): when child_done_i[cur_idx] is seen, advance the pointer to cur_idx+1 and go to SCAN.
  - Otherwise the counter increments. If the counter reaches timeout_cfg (nonzero), set status_o[cur_idx], advance the pointer and go to SCAN.
  - If done and the limit coincide in the same cycle, done wins and no flag is set.
- WAIT (parallel): OR child_done_i into the sticky vector. When sticky covers the mask, go to FINISH.
  - On timeout, set status_o = mask & ~sticky and go to FINISH.
  - Same-cycle rule: done bits present in the timeout cycle count as done.
- Timeout numbering: with ISSUE at cycle T, WAIT occupies T+1..T+timeout_cfg. The timeout decision is made in cycle T+timeout_cfg, and the next state starts at T+timeout_cfg+1.
- FINISH: done_o = 1 for one cycle, busy_o still 1. Next cycle returns to IDLE with busy_o = 0. A start_i in FINISH is ignored.
- Sequential latency: a child whose done arrives k cycles after its start pulse (k >= 1) has its successor's SCAN at T+k+1 and its successor's ISSUE at T+k+2.
- An all-zero mask gives IDLE -> SCAN -> FINISH: done_o in the second cycle after start is accepted, with no start pulses.
- cur_idx_o never exceeds NUM_CHILD-1. The pointer wrap past the last child terminates the run; it never revisits index 0.

Test Plan:
- NUM_CHILD=5, sequential, mask=5'b11111, timeout=0, each child asserts done 3 cycles after its start -> start pulses on children 0..4 in order, spaced 5 cycles apart; done_o once; status_o=0.
- Sequential, mask=5'b10101, timeout=4, child 2 never responds -> pulses only on 0, 2, 4; child 2 holds WAIT 4 cycles; status_o=5'b00100; children 1 and 3 never pulsed.
- Parallel, mask=5'b01111, timeout=10, dones at +2, +5, +7 for children 0, 1, 2 and none for child 3 -> one simultaneous pulse on bits 0..3; done_o 11 cycles after the ISSUE cycle; status_o=5'b01000.
- Sequential, timeout=3, child 0 done coincides with the counter limit -> no flag; run continues to child 1.
- mask=0 -> done_o 2 cycles after start, no child_start_o activity; a start_i pulsed while busy_o=1 -> ignored, exactly one done_o.
- Reset asserted during WAIT of child 2 -> next cycle all outputs 0, state IDLE; a fresh start then runs from child 0.
